// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: branch funct3 codes,
// 2-bit predictor counter encodings and a funct3 legality helper.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] CNT_RESET = CNT_WNT;

    // 010 and 011 are the only undefined branch encodings.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return !(f3[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// One 2-bit saturating predictor counter. When en is high it moves one
// step toward strong-taken (inc=1) or strong-not-taken (inc=0) and holds
// at either end. Resets asynchronously to weak-not-taken.
module sat_counter2
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       inc,
    output logic [1:0] cnt
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: step in the requested direction unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (inc) begin
                if (cnt_q != CNT_ST) cnt_d = cnt_q + 2'd1;
            end else begin
                if (cnt_q != CNT_SNT) cnt_d = cnt_q - 2'd1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= CNT_RESET;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution plus an untagged BHT of 2-bit counters read
// combinationally by IF. Resolution (ex_taken, mispredict, BrUn) is purely
// combinational; the BHT and optional stats update on the rising edge when
// a live, unstalled conditional branch is in EX.
// Optional build macro: BRANCH_STATS_EN adds saturating stat_branches and
// stat_mispredicts counters and their output ports.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16   // power of two, at least 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        ex_valid,
    input  logic        ex_stall,
    input  logic        ex_is_branch,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic        BrEq,
    input  logic        BrLT,
    output logic        BrUn,
    output logic        ex_taken,
    output logic        mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0]                if_idx;
    logic [IDX_W-1:0]                ex_idx;
    logic [BHT_ENTRIES-1:0][1:0]     bht;
    logic                            ex_branch;
    logic                            ex_resolve;
    logic                            ex_legal;
    logic                            bht_update;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Only the index bits of the PCs and the prediction bit of each counter
    // feed logic; fold the rest here so they are visibly accounted for.
    logic unused_bits;
    assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                           ex_pc[31:IDX_W+2], ex_pc[1:0], bht};

    // Comparator signedness follows funct3[1] regardless of valid.
    assign BrUn = ex_funct3[1];

    assign ex_branch  = ex_valid & ex_is_branch;
    assign ex_resolve = ex_branch & ~ex_stall;
    assign ex_legal   = f3_is_legal(ex_funct3);
    assign bht_update = ex_resolve & ex_legal;

    // Branch outcome decode; illegal encodings resolve not-taken.
    always_comb begin
        ex_taken = 1'b0;
        if (ex_branch) begin
            case (ex_funct3)
                F3_BEQ:           ex_taken = BrEq;
                F3_BNE:           ex_taken = ~BrEq;
                F3_BLT, F3_BLTU:  ex_taken = BrLT;
                F3_BGE, F3_BGEU:  ex_taken = ~BrLT;
                default:          ex_taken = 1'b0;
            endcase
        end
    end

    // A stalled branch never flushes; it resolves when the stall drops.
    always_comb begin
        mispredict = ex_resolve & (ex_taken != ex_pred_taken);
    end

    // BHT: one saturating counter per index; only the EX-addressed entry
    // steps. IF reads the registered value, so a same-edge update is not
    // visible until the following cycle.
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        sat_counter2 u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bht_update && (ex_idx == IDX_W'(gi))),
            .inc   (ex_taken),
            .cnt   (bht[gi])
        );
    end

    assign if_pred_taken = bht[if_idx][1];

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_branches_d;
    logic [31:0] stat_mispredicts_q;
    logic [31:0] stat_mispredicts_d;

    // Saturating event counts, qualified on the same edge as the BHT.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bht_update && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    // Stats registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
